// File: rtl/reg_file_pkg.sv
// Shared types and constants for the RV32 integer register file.
package reg_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_XLEN   = 32;

    localparam logic [REG_ADDR_W-1:0] REGISTER_X0 = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } reg_file_read_params_t;

    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_XLEN-1:0]   data;
    } reg_file_write_params_t;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } reg_file_state_t;

endpackage

// File: rtl/reg_file_core_if.sv
// Decode read request/response and retire writeback bundle for reg_file_core.
interface reg_file_core_if #(
    parameter int XLEN = 32
);
    import reg_file_pkg::*;

    logic                  rd_req_valid;
    reg_file_read_params_t rd_req_params;
    logic                  rd_req_ready;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [REG_ADDR_W-1:0] rd_dest;
    logic                  rd_data_valid;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [XLEN-1:0]       wb_data;
    logic                  init_done;

    modport master (
        output rd_req_valid, rd_req_params, wb_en, wb_addr, wb_data,
        input  rd_req_ready, rs1_data, rs2_data, rd_dest, rd_data_valid, init_done
    );

    modport slave (
        input  rd_req_valid, rd_req_params, wb_en, wb_addr, wb_data,
        output rd_req_ready, rs1_data, rs2_data, rd_dest, rd_data_valid, init_done
    );

endinterface

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks x1..x(NUM_REGS-1) writing zero, then parks in READY.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  clr_we_o,
    output logic [REG_ADDR_W-1:0] clr_idx_o,
    output logic                  init_done_o
);

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

    reg_file_state_t       state_q, state_d;
    logic [REG_ADDR_W-1:0] clr_idx_q, clr_idx_d;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= REG_ADDR_W'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // NOTE: every output is defaulted before the case so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        clr_we_o    = 1'b0;
        init_done_o = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_o  = 1'b1;
                clr_idx_d = clr_idx_q + REG_ADDR_W'(1);
                if (clr_idx_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                init_done_o = 1'b1;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign clr_idx_o = clr_idx_q;

endmodule

// File: rtl/reg_file_core.sv
// Integer register file: clear-on-reset array, one writeback port, two registered read ports.
// Define REG_FILE_WB_BYPASS_EN to forward same-edge writeback data onto read results.
module reg_file_core
    import reg_file_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic           clk,
    input  logic           rst,
    reg_file_core_if.slave bus
);

    logic                  clr_we;
    logic [REG_ADDR_W-1:0] clr_idx;
    logic                  init_done;
    logic                  accept;
    logic                  wb_we;
    reg_file_read_params_t req;
    logic [XLEN-1:0]       rs1_val, rs2_val;

    logic [XLEN-1:0]       regs_q [1:NUM_REGS-1];
    logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
    logic [REG_ADDR_W-1:0] rd_dest_q, rd_dest_d;
    logic                  rd_valid_q, rd_valid_d;

    reg_file_clear_seq #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .clr_we_o    (clr_we),
        .clr_idx_o   (clr_idx),
        .init_done_o (init_done)
    );

    assign req    = bus.rd_req_params;
    assign accept = bus.rd_req_valid & init_done;
    assign wb_we  = init_done & bus.wb_en & (bus.wb_addr != REGISTER_X0);

    // NOTE: the array has no reset; the clear sequencer zeroes it after reset instead.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs_q[clr_idx] <= '0;
        end else if (wb_we) begin
            regs_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    // x0 has no storage, so its override comes last and wins over any forwarded value.
    always_comb begin
        rs1_val = regs_q[req.rs1];
        rs2_val = regs_q[req.rs2];
`ifdef REG_FILE_WB_BYPASS_EN
        if (wb_we && (req.rs1 == bus.wb_addr)) rs1_val = bus.wb_data;
        if (wb_we && (req.rs2 == bus.wb_addr)) rs2_val = bus.wb_data;
`endif
        if (req.rs1 == REGISTER_X0) rs1_val = '0;
        if (req.rs2 == REGISTER_X0) rs2_val = '0;
    end

    always_comb begin
        rd_valid_d = accept;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_dest_d  = rd_dest_q;
        if (accept) begin
            rs1_data_d = rs1_val;
            rs2_data_d = rs2_val;
            rd_dest_d  = req.rd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_dest_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_dest_q  <= rd_dest_d;
        end
    end

    assign bus.rd_req_ready  = init_done;
    assign bus.init_done     = init_done;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.rs1_data      = rs1_data_q;
    assign bus.rs2_data      = rs2_data_q;
    assign bus.rd_dest       = rd_dest_q;

endmodule

// File: tb/tb_reg_file_core.sv
// Self-checking bench for reg_file_core: directed scenarios plus a randomized stream
// checked every cycle against an array-based model (honours REG_FILE_WB_BYPASS_EN).
module tb_reg_file_core;
    import reg_file_pkg::*;

    localparam int XLEN         = 32;
    localparam int NUM_REGS     = 32;
    localparam int CLEAR_CYCLES = NUM_REGS - 1;
`ifdef REG_FILE_WB_BYPASS_EN
    localparam logic [31:0] COLLIDE_EXP = 32'h2;
`else
    localparam logic [31:0] COLLIDE_EXP = 32'h1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    reg_file_core_if #(.XLEN(XLEN)) bus ();

    reg_file_core #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles since reset release, a plain register array, expected outputs.
    int unsigned     edges_since_rst = 0;
    logic [XLEN-1:0] mdl_regs [NUM_REGS];
    bit              exp_valid = 1'b0;
    logic [XLEN-1:0] exp_rs1 = '0;
    logic [XLEN-1:0] exp_rs2 = '0;
    logic [4:0]      exp_rd  = '0;

    function automatic logic [XLEN-1:0] mdl_read(input logic [4:0] idx, input logic wen,
                                                 input logic [4:0] waddr, input logic [XLEN-1:0] wdata);
        if (idx == 5'd0) return '0;
`ifdef REG_FILE_WB_BYPASS_EN
        if (wen && waddr == idx) return wdata;
`endif
        return mdl_regs[idx];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            edges_since_rst = 0;
            exp_valid = 1'b0;
            exp_rs1 = '0;
            exp_rs2 = '0;
            exp_rd  = '0;
            foreach (mdl_regs[i]) mdl_regs[i] = '0;
        end else if (edges_since_rst < CLEAR_CYCLES) begin
            edges_since_rst++;
            exp_valid = 1'b0;
        end else begin
            exp_valid = bus.rd_req_valid;
            if (bus.rd_req_valid) begin
                exp_rs1 = mdl_read(bus.rd_req_params.rs1, bus.wb_en, bus.wb_addr, bus.wb_data);
                exp_rs2 = mdl_read(bus.rd_req_params.rs2, bus.wb_en, bus.wb_addr, bus.wb_data);
                exp_rd  = bus.rd_req_params.rd;
            end
            if (bus.wb_en && bus.wb_addr != 5'd0) mdl_regs[bus.wb_addr] = bus.wb_data;
        end
    end

    always @(negedge clk) begin
        check("rd_req_ready", 32'(bus.rd_req_ready), 32'(!rst && edges_since_rst >= CLEAR_CYCLES));
        check("init_done",    32'(bus.init_done),    32'(!rst && edges_since_rst >= CLEAR_CYCLES));
        check("rd_data_valid", 32'(bus.rd_data_valid), 32'(exp_valid));
        check("rs1_data", bus.rs1_data, exp_rs1);
        check("rs2_data", bus.rs2_data, exp_rs2);
        check("rd_dest",  32'(bus.rd_dest), 32'(exp_rd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        bus.rd_req_valid  = 1'b1;
        bus.rd_req_params = '{rs1: a, rs2: b, rd: d};
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
    endtask

    task automatic idle();
        bus.rd_req_valid = 1'b0;
        bus.wb_en        = 1'b0;
    endtask

    task automatic random_burst(input int n);
        for (int i = 0; i < n; i++) begin
            bus.rd_req_valid  = ($urandom_range(0, 3) != 0);
            bus.rd_req_params = '{rs1: 5'($urandom_range(0, 7)), rs2: 5'($urandom), rd: 5'($urandom)};
            bus.wb_en         = $urandom_range(0, 1) == 1;
            bus.wb_addr       = 5'($urandom_range(0, 7));
            bus.wb_data       = $urandom;
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Writeback held during reset and clear must be dropped.
        req(5'd5, 5'd31, 5'd1);
        wb(5'd5, 32'hFFFF_FFFF);
        repeat (2) tick();
        rst = 1'b0;
        check("ready_at_release", 32'(bus.rd_req_ready), 32'd0);
        for (int k = 1; k <= CLEAR_CYCLES; k++) begin
            tick();
            check("ready_during_clear", 32'(bus.rd_req_ready), 32'(k == CLEAR_CYCLES));
        end
        check("init_done_rise", 32'(bus.init_done), 32'd1);
        bus.wb_en = 1'b0;
        tick();
        idle();
        check("first_read_valid", 32'(bus.rd_data_valid), 32'd1);
        check("first_read_rs1", bus.rs1_data, 32'd0);
        check("first_read_rs2", bus.rs2_data, 32'd0);

        wb(5'd7, 32'hDEAD_BEEF);
        tick();
        bus.wb_en = 1'b0;
        req(5'd7, 5'd0, 5'd9);
        tick();
        idle();
        check("x7_rs1", bus.rs1_data, 32'hDEAD_BEEF);
        check("x7_rs2", bus.rs2_data, 32'd0);
        check("x7_rd", 32'(bus.rd_dest), 32'd9);
        check("x7_valid", 32'(bus.rd_data_valid), 32'd1);
        tick();
        check("x7_valid_drop", 32'(bus.rd_data_valid), 32'd0);
        check("x7_hold", bus.rs1_data, 32'hDEAD_BEEF);

        wb(5'd0, 32'h1234_5678);
        tick();
        bus.wb_en = 1'b0;
        req(5'd0, 5'd7, 5'd2);
        tick();
        idle();
        check("x0_read", bus.rs1_data, 32'd0);
        check("x0_other_port", bus.rs2_data, 32'hDEAD_BEEF);

        wb(5'd3, 32'h1);
        tick();
        wb(5'd3, 32'h2);
        req(5'd3, 5'd3, 5'd3);
        tick();
        idle();
        check("collide_rs1", bus.rs1_data, COLLIDE_EXP);
        check("collide_rs2", bus.rs2_data, COLLIDE_EXP);

        wb(5'd1, 32'hA);
        tick();
        wb(5'd2, 32'hB);
        tick();
        wb(5'd3, 32'hC);
        tick();
        bus.wb_en = 1'b0;
        req(5'd1, 5'd1, 5'd4);
        tick();
        req(5'd2, 5'd0, 5'd5);
        check("b2b_0_rs1", bus.rs1_data, 32'hA);
        check("b2b_0_rd", 32'(bus.rd_dest), 32'd4);
        tick();
        req(5'd3, 5'd2, 5'd6);
        check("b2b_1_rs1", bus.rs1_data, 32'hB);
        check("b2b_1_rd", 32'(bus.rd_dest), 32'd5);
        tick();
        idle();
        check("b2b_2_rs1", bus.rs1_data, 32'hC);
        check("b2b_2_rs2", bus.rs2_data, 32'hB);
        check("b2b_2_rd", 32'(bus.rd_dest), 32'd6);
        check("b2b_2_valid", 32'(bus.rd_data_valid), 32'd1);
        tick();
        check("b2b_end_valid", 32'(bus.rd_data_valid), 32'd0);

        random_burst(1500);

        // Reset in the middle of a read stream, then confirm the array was cleared.
        idle();
        wb(5'd7, 32'hDEAD_BEEF);
        tick();
        bus.wb_en = 1'b0;
        req(5'd7, 5'd7, 5'd7);
        repeat (3) tick();
        check("pre_rst_valid", 32'(bus.rd_data_valid), 32'd1);
        check("pre_rst_rs1", bus.rs1_data, 32'hDEAD_BEEF);
        rst = 1'b1;
        #1;
        check("async_valid_drop", 32'(bus.rd_data_valid), 32'd0);
        check("async_ready_drop", 32'(bus.rd_req_ready), 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        n = 0;
        while (!bus.rd_req_ready && n < 40) begin
            tick();
            n++;
        end
        check("clear_restart_cycles", 32'(n), 32'(CLEAR_CYCLES));
        tick();
        idle();
        check("x7_after_reset", bus.rs1_data, 32'd0);
        check("x7_after_reset_valid", 32'(bus.rd_data_valid), 32'd1);

        random_burst(500);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
